// File: rtl/sdr_pkg.sv
// Shared definitions for the SDRAM command-bus arbiter: state width and encodings.
package sdr_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_INIT  = 4'd0,
    S_IDLE  = 4'd1,
    S_WRITE = 4'd2,
    S_READ  = 4'd3,
    S_REF   = 4'd4
  } sdr_state_t;

endpackage

// File: rtl/sdr_ref_timer.sv
// Auto-refresh interval timer and postponed-refresh counter.
// The timer free-runs 0..REF_PERIOD-1 once enabled; each wrap is one refresh
// demand. Demands accumulate in ref_pend up to REF_MAX_PEND. A demand that
// arrives with the counter already full is lost and flagged in sticky ref_ovf.
module sdr_ref_timer #(
  parameter  int REF_PERIOD   = 1300,
  parameter  int REF_MAX_PEND = 4,
  localparam int CNT_W        = $clog2(REF_PERIOD),
  localparam int PEND_W       = $clog2(REF_MAX_PEND + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              ref_done_ack,
  output logic [PEND_W-1:0] ref_pend,
  output logic              ref_ovf
);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REF_PERIOD - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(REF_MAX_PEND);

  logic [CNT_W-1:0] cnt;
  logic             tick;

  assign tick = en && (cnt == CNT_LAST);

  // Interval timer: parked at 0 until enabled, then counts and wraps.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Pending counter: a tick and an ack in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_pend <= '0;
      ref_ovf  <= 1'b0;
    end else if (tick && !ref_done_ack) begin
      if (ref_pend == PEND_MAX) begin
        ref_ovf <= 1'b1;
      end else begin
        ref_pend <= ref_pend + 1'b1;
      end
    end else if (ref_done_ack && !tick) begin
      if (ref_pend != '0) begin
        ref_pend <= ref_pend - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdr_arb.sv
// SDRAM command-bus arbiter between write, read and auto-refresh sequencers.
// Handshake: sdr_wr_req/sdr_rd_req are levels held until the matching grant
// rises; a grant then stays high until the owner's single-cycle completion
// strobe (wr_exit/rd_done/ref_done) is sampled, after which the arbiter spends
// at least one cycle in S_IDLE before granting again. Grants are registered
// alongside the state so they always match sdr_state.
module sdr_arb
  import sdr_pkg::*;
#(
  parameter int REF_PERIOD   = 1300,
  parameter int REF_MAX_PEND = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init_done,
  input  logic               sdr_wr_req,
  input  logic               sdr_rd_req,
  input  logic               wr_exit,
  input  logic               rd_done,
  input  logic               ref_done,
  output logic               wr_grant,
  output logic               rd_grant,
  output logic               ref_grant,
  output logic [STATE_W-1:0] sdr_state,
  output logic               ref_urgent,
  output logic               ref_ovf
);

  localparam int PEND_W = $clog2(REF_MAX_PEND + 1);

  sdr_state_t        state_q;
  logic              last_rd;   // 1 when the most recent data grant was a read
  logic [PEND_W-1:0] ref_pend;
  logic              ref_done_ack;

  assign sdr_state    = state_q;
  assign ref_done_ack = ref_done && (state_q == S_REF);
  assign ref_urgent   = (ref_pend == PEND_W'(REF_MAX_PEND));

  sdr_ref_timer #(
    .REF_PERIOD  (REF_PERIOD),
    .REF_MAX_PEND(REF_MAX_PEND)
  ) u_ref (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (init_done),
    .ref_done_ack(ref_done_ack),
    .ref_pend    (ref_pend),
    .ref_ovf     (ref_ovf)
  );

  // Arbiter FSM with grants registered together with the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_INIT;
      wr_grant  <= 1'b0;
      rd_grant  <= 1'b0;
      ref_grant <= 1'b0;
      last_rd   <= 1'b1;
    end else begin
      case (state_q)
        S_INIT: begin
          if (init_done) begin
            state_q <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (ref_urgent) begin
            state_q   <= S_REF;
            ref_grant <= 1'b1;
          end else if (sdr_wr_req && (!sdr_rd_req || last_rd)) begin
            state_q  <= S_WRITE;
            wr_grant <= 1'b1;
            last_rd  <= 1'b0;
          end else if (sdr_rd_req) begin
            state_q  <= S_READ;
            rd_grant <= 1'b1;
            last_rd  <= 1'b1;
          end else if (ref_pend != '0) begin
            state_q   <= S_REF;
            ref_grant <= 1'b1;
          end
        end
        S_WRITE: begin
          if (wr_exit) begin
            state_q  <= S_IDLE;
            wr_grant <= 1'b0;
          end
        end
        S_READ: begin
          if (rd_done) begin
            state_q  <= S_IDLE;
            rd_grant <= 1'b0;
          end
        end
        S_REF: begin
          if (ref_done) begin
            state_q   <= S_IDLE;
            ref_grant <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_INIT;
          wr_grant  <= 1'b0;
          rd_grant  <= 1'b0;
          ref_grant <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdr_arb.sv
// Directed bench for sdr_arb with REF_PERIOD=16, REF_MAX_PEND=2.
// Edge numbering in comments: E1 is the first edge that samples init_done=1.
module tb_sdr_arb;
  import sdr_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       init_done;
  logic       sdr_wr_req;
  logic       sdr_rd_req;
  logic       wr_exit;
  logic       rd_done;
  logic       ref_done;
  logic       wr_grant;
  logic       rd_grant;
  logic       ref_grant;
  logic [3:0] sdr_state;
  logic       ref_urgent;
  logic       ref_ovf;

  int n_checks;
  int n_errors;
  logic [3:0] exp_q[$];

  sdr_arb #(
    .REF_PERIOD  (16),
    .REF_MAX_PEND(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .sdr_wr_req(sdr_wr_req),
    .sdr_rd_req(sdr_rd_req),
    .wr_exit   (wr_exit),
    .rd_done   (rd_done),
    .ref_done  (ref_done),
    .wr_grant  (wr_grant),
    .rd_grant  (rd_grant),
    .ref_grant (ref_grant),
    .sdr_state (sdr_state),
    .ref_urgent(ref_urgent),
    .ref_ovf   (ref_ovf)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: advance n edges; inputs are driven and outputs sampled 1 ns later
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ref_done();
    ref_done = 1'b1;
    step(1);
    ref_done = 1'b0;
  endtask

  // Checker
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_s;
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    init_done  = 1'b0;
    sdr_wr_req = 1'b0;
    sdr_rd_req = 1'b0;
    wr_exit    = 1'b0;
    rd_done    = 1'b0;
    ref_done   = 1'b0;

    // Reset state
    step(2);
    chk("rst_state", sdr_state, 0);
    chk("rst_grants", {wr_grant, rd_grant, ref_grant}, 0);
    chk("rst_pend", dut.u_ref.ref_pend, 0);
    chk("rst_ovf", ref_ovf, 0);
    chk("rst_urgent", ref_urgent, 0);
    chk("rst_timer", dut.u_ref.cnt, 0);

    // Init: stay in S_INIT with timer parked until init_done
    rst_n = 1'b1;
    step(3);
    chk("pre_init_state", sdr_state, 0);
    chk("pre_init_timer", dut.u_ref.cnt, 0);
    chk("pre_init_grants", {wr_grant, rd_grant, ref_grant}, 0);
    init_done = 1'b1;
    step(1);                                    // E1
    chk("init_idle", sdr_state, 1);

    // Refresh fill: first tick at E16, refresh taken at E17
    step(14);                                   // E15
    chk("fill_pend0", dut.u_ref.ref_pend, 0);
    step(1);                                    // E16
    chk("fill_pend1", dut.u_ref.ref_pend, 1);
    chk("fill_still_idle", sdr_state, 1);
    step(1);                                    // E17
    chk("fill_ref_state", sdr_state, 4);
    chk("fill_ref_grant", ref_grant, 1);
    pulse_ref_done();                           // E18
    chk("fill_pend_back0", dut.u_ref.ref_pend, 0);
    chk("fill_back_idle", sdr_state, 1);
    chk("fill_ref_grant_low", ref_grant, 0);

    // Contention: alternate W,R,W,R with one idle cycle between grants
    exp_q.push_back(S_WRITE);
    exp_q.push_back(S_READ);
    exp_q.push_back(S_WRITE);
    exp_q.push_back(S_READ);
    sdr_wr_req = 1'b1;
    sdr_rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_s = exp_q.pop_front();
      step(1);
      chk("rr_state", sdr_state, exp_s);
      chk("rr_grants", {wr_grant, rd_grant, ref_grant},
          {exp_s == S_WRITE, exp_s == S_READ, 1'b0});
      step(2);
      if (exp_s == S_WRITE) wr_exit = 1'b1;
      else rd_done = 1'b1;
      step(1);
      wr_exit = 1'b0;
      rd_done = 1'b0;
      chk("rr_gap_state", sdr_state, 1);
      chk("rr_gap_grants", {wr_grant, rd_grant, ref_grant}, 0);
    end                                         // E34
    chk("rr_pend_after_tick", dut.u_ref.ref_pend, 1);
    sdr_wr_req = 1'b0;
    sdr_rd_req = 1'b0;
    step(1);                                    // E35
    chk("rr_then_ref", sdr_state, 4);
    pulse_ref_done();                           // E36
    chk("rr_ref_pend0", dut.u_ref.ref_pend, 0);

    // Urgency: long write fills ref_pend; refresh beats the waiting read
    sdr_wr_req = 1'b1;
    step(1);                                    // E37
    chk("urg_write", sdr_state, 2);
    sdr_wr_req = 1'b0;
    sdr_rd_req = 1'b1;
    step(39);                                   // E76
    chk("urg_pend2", dut.u_ref.ref_pend, 2);
    chk("urg_flag", ref_urgent, 1);
    chk("urg_no_preempt", sdr_state, 2);
    chk("urg_wr_grant", wr_grant, 1);
    wr_exit = 1'b1;
    step(1);                                    // E77
    wr_exit = 1'b0;
    chk("urg_idle_gap", sdr_state, 1);
    step(1);                                    // E78
    chk("urg_ref_first", sdr_state, 4);
    chk("urg_rd_grant_low", rd_grant, 0);
    pulse_ref_done();                           // E79
    chk("urg_pend1", dut.u_ref.ref_pend, 1);
    step(1);                                    // E80: read granted, tick
    chk("urg_read", sdr_state, 3);
    chk("urg_pend_tick", dut.u_ref.ref_pend, 2);
    sdr_rd_req = 1'b0;
    rd_done    = 1'b1;
    step(1);                                    // E81
    rd_done = 1'b0;
    chk("urg_read_done", sdr_state, 1);
    step(1);                                    // E82
    chk("urg_ref_again", sdr_state, 4);
    pulse_ref_done();                           // E83
    step(1);                                    // E84
    chk("sim_ref", sdr_state, 4);

    // Stray strobe outside its state is ignored
    wr_exit = 1'b1;
    step(1);                                    // E85
    wr_exit = 1'b0;
    chk("stray_wr_exit", sdr_state, 4);

    // Tick coincident with ref_done at ref_pend=1
    step(10);                                   // E95
    pulse_ref_done();                           // E96
    chk("sim_pend_held", dut.u_ref.ref_pend, 1);
    chk("sim_no_ovf", ref_ovf, 0);
    step(1);                                    // E97
    chk("ovf_ref", sdr_state, 4);
    step(15);                                   // E112
    chk("ovf_pend2", dut.u_ref.ref_pend, 2);
    chk("ovf_not_yet", ref_ovf, 0);
    step(16);                                   // E128
    chk("ovf_pend_sat", dut.u_ref.ref_pend, 2);
    chk("ovf_set", ref_ovf, 1);
    pulse_ref_done();                           // E129
    chk("ovf_pend_dec", dut.u_ref.ref_pend, 1);
    chk("ovf_sticky", ref_ovf, 1);
    step(1);                                    // E130
    pulse_ref_done();                           // E131
    chk("ovf_pend0", dut.u_ref.ref_pend, 0);

    // Reset mid-write, then first tie after reset goes to write
    sdr_wr_req = 1'b1;
    step(1);                                    // E132
    chk("mid_write", sdr_state, 2);
    rst_n = 1'b0;
    step(1);                                    // E133
    rst_n = 1'b1;
    chk("mid_rst_state", sdr_state, 0);
    chk("mid_rst_wr_grant", wr_grant, 0);
    chk("mid_rst_pend", dut.u_ref.ref_pend, 0);
    chk("mid_rst_ovf", ref_ovf, 0);
    sdr_rd_req = 1'b1;
    step(1);                                    // E134
    chk("post_rst_idle", sdr_state, 1);
    step(1);                                    // E135
    chk("post_rst_tie_write", sdr_state, 2);
    chk("post_rst_wr_grant", {wr_grant, rd_grant}, 2'b10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
